// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator (retrigger > free voice > steal oldest), one voice scanned per clock
//   clk, rst            clock, synchronous active-high reset
//   note_on, note_off   one-cycle event strobes, note sampled on acceptance
//   busy, drop          event in progress / strobe discarded (one-cycle pulse)
//   voice_gate/note/trig per-voice gate, note number, one-cycle (re)assign pulse
module voice_alloc #(
   parameter int VOICES = 4,
   parameter int NOTE_W = 7,
   parameter int AGE_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     note_on,
   input  logic                     note_off,
   input  logic [NOTE_W-1:0]        note,
   output logic                     busy,
   output logic                     drop,
   output logic [VOICES-1:0]        voice_gate,
   output logic [VOICES*NOTE_W-1:0] voice_note,
   output logic [VOICES-1:0]        voice_trig
);
   localparam int IW = $clog2(VOICES);
   typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
   state_t state, state_nx;
   logic [IW-1:0] idx, t, match_idx, free_idx, old_idx;
   logic match_ok, free_ok, is_on, accept;
   logic [NOTE_W-1:0] lnote;
   logic [AGE_W-1:0] age [VOICES];
   assign busy   = state != IDLE;
   assign accept = !busy && (note_on || note_off);
   always_comb begin
      state_nx = state == IDLE ? (accept ? SCAN : IDLE) :
                 state == SCAN ? (idx == IW'(VOICES-1) ? APPLY : SCAN) : IDLE;
      t = match_ok ? match_idx : free_ok ? free_idx : old_idx;
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         match_idx  <= '0;
         free_idx   <= '0;
         old_idx    <= '0;
         match_ok   <= 1'b0;
         free_ok    <= 1'b0;
         is_on      <= 1'b0;
         lnote      <= '0;
         drop       <= 1'b0;
         voice_gate <= '0;
         voice_note <= '0;
         voice_trig <= '0;
         for (int i = 0; i < VOICES; i++) age[i] <= AGE_W'(i);
      end else begin
         voice_trig <= '0;
         // busy strobes are lost; a simultaneous on+off while idle loses the off
         drop <= (busy && (note_on || note_off)) || (!busy && note_on && note_off);
         if (accept) begin
            lnote    <= note;
            is_on    <= note_on;
            idx      <= '0;
            match_ok <= 1'b0;
            free_ok  <= 1'b0;
         end
         if (state == SCAN) begin
            idx <= idx + 1'b1;
            if (!match_ok && voice_gate[idx] && voice_note[idx*NOTE_W +: NOTE_W] == lnote) begin
               match_ok  <= 1'b1;
               match_idx <= idx;
            end
            if (!free_ok && !voice_gate[idx]) begin
               free_ok  <= 1'b1;
               free_idx <= idx;
            end
            if (age[idx] == AGE_W'(VOICES-1)) old_idx <= idx;
         end
         if (state == APPLY) begin
            if (is_on) begin
               voice_gate[t]                 <= 1'b1;
               voice_note[t*NOTE_W +: NOTE_W] <= lnote;
               voice_trig[t]                 <= 1'b1;
               // younger voices age by one, target becomes youngest: ages stay a permutation
               for (int j = 0; j < VOICES; j++)
                  age[j] <= IW'(j) == t ? '0 : age[j] < age[t] ? age[j] + 1'b1 : age[j];
            end else begin
               for (int j = 0; j < VOICES; j++)
                  if (voice_gate[j] && voice_note[j*NOTE_W +: NOTE_W] == lnote) voice_gate[j] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed vector bench for voice_alloc (VOICES=4, NOTE_W=7)
module tb_voice_alloc;
   localparam int V = 4, NW = 7;
   logic clk = 1'b0, rst = 1'b1, note_on = 1'b0, note_off = 1'b0;
   logic [NW-1:0] note = '0;
   logic busy, drop;
   logic [V-1:0] voice_gate, voice_trig;
   logic [V*NW-1:0] voice_note;
   int total = 0, bad = 0;
   typedef struct {
      logic        rst_first, on, off;
      logic [6:0]  n;
      logic [3:0]  gate;
      logic [27:0] notes;
      logic [3:0]  trig;
   } vec_t;
   vec_t tv[18];
   always #5 clk = ~clk;
   voice_alloc #(.VOICES(V), .NOTE_W(NW), .AGE_W(4)) dut (
      .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off), .note(note),
      .busy(busy), .drop(drop), .voice_gate(voice_gate), .voice_note(voice_note),
      .voice_trig(voice_trig)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      tv[0]  = '{0, 1, 0, 60,  4'b0001, {7'd0,  7'd0,   7'd0,  7'd60}, 4'b0001};
      tv[1]  = '{0, 1, 0, 60,  4'b0001, {7'd0,  7'd0,   7'd0,  7'd60}, 4'b0001};
      tv[2]  = '{0, 1, 0, 62,  4'b0011, {7'd0,  7'd0,   7'd62, 7'd60}, 4'b0010};
      tv[3]  = '{0, 1, 0, 64,  4'b0111, {7'd0,  7'd64,  7'd62, 7'd60}, 4'b0100};
      tv[4]  = '{0, 1, 0, 67,  4'b1111, {7'd67, 7'd64,  7'd62, 7'd60}, 4'b1000};
      tv[5]  = '{0, 0, 1, 62,  4'b1101, {7'd67, 7'd64,  7'd62, 7'd60}, 4'b0000};
      tv[6]  = '{0, 1, 0, 72,  4'b1111, {7'd67, 7'd64,  7'd72, 7'd60}, 4'b0010};
      tv[7]  = '{0, 1, 0, 74,  4'b1111, {7'd67, 7'd64,  7'd72, 7'd74}, 4'b0001};
      tv[8]  = '{0, 0, 1, 99,  4'b1111, {7'd67, 7'd64,  7'd72, 7'd74}, 4'b0000};
      tv[9]  = '{0, 1, 0, 127, 4'b1111, {7'd67, 7'd127, 7'd72, 7'd74}, 4'b0100};
      tv[10] = '{0, 0, 1, 74,  4'b1110, {7'd67, 7'd127, 7'd72, 7'd74}, 4'b0000};
      tv[11] = '{0, 1, 0, 0,   4'b1111, {7'd67, 7'd127, 7'd72, 7'd0},  4'b0001};
      tv[12] = '{1, 1, 0, 60,  4'b0001, {7'd0,  7'd0,   7'd0,  7'd60}, 4'b0001};
      tv[13] = '{0, 1, 0, 62,  4'b0011, {7'd0,  7'd0,   7'd62, 7'd60}, 4'b0010};
      tv[14] = '{0, 1, 0, 64,  4'b0111, {7'd0,  7'd64,  7'd62, 7'd60}, 4'b0100};
      tv[15] = '{0, 1, 0, 67,  4'b1111, {7'd67, 7'd64,  7'd62, 7'd60}, 4'b1000};
      tv[16] = '{0, 1, 0, 72,  4'b1111, {7'd67, 7'd64,  7'd62, 7'd72}, 4'b0001};
      tv[17] = '{0, 1, 0, 80,  4'b1111, {7'd67, 7'd64,  7'd80, 7'd72}, 4'b0010};
      step();
      chk("reset busy", 32'(busy), 0);
      chk("reset drop", 32'(drop), 0);
      chk("reset gate", 32'(voice_gate), 0);
      chk("reset notes", 32'(voice_note), 0);
      chk("reset trig", 32'(voice_trig), 0);
      rst = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (tv[i].rst_first) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         note_on = tv[i].on; note_off = tv[i].off; note = tv[i].n;
         step();
         chk($sformatf("v%0d busy start", i), 32'(busy), 1);
         note_on = 1'b0; note_off = 1'b0;
         repeat (V) step();
         chk($sformatf("v%0d busy apply", i), 32'(busy), 1);
         step();
         chk($sformatf("v%0d busy done", i), 32'(busy), 0);
         chk($sformatf("v%0d gate", i), 32'(voice_gate), 32'(tv[i].gate));
         chk($sformatf("v%0d notes", i), 32'(voice_note), 32'(tv[i].notes));
         chk($sformatf("v%0d trig", i), 32'(voice_trig), 32'(tv[i].trig));
         step();
         chk($sformatf("v%0d trig clear", i), 32'(voice_trig), 0);
      end
      // reset in cycle 3 of a scan aborts the event and clears everything
      note_on = 1'b1; note = 7'd33;
      step();
      note_on = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      chk("midrst busy", 32'(busy), 0);
      chk("midrst gate", 32'(voice_gate), 0);
      chk("midrst notes", 32'(voice_note), 0);
      chk("midrst trig", 32'(voice_trig), 0);
      chk("midrst drop", 32'(drop), 0);
      rst = 1'b0;
      repeat (8) step();
      chk("midrst no apply gate", 32'(voice_gate), 0);
      chk("midrst no apply notes", 32'(voice_note), 0);
      // simultaneous on+off, then a note_on while busy
      note_on = 1'b1; note_off = 1'b1; note = 7'd50;
      step();
      chk("dual drop c1", 32'(drop), 1);
      chk("dual busy c1", 32'(busy), 1);
      note_on = 1'b0; note_off = 1'b0;
      step();
      chk("dual drop c2", 32'(drop), 0);
      note_on = 1'b1; note = 7'd55;
      step();
      chk("busy drop c3", 32'(drop), 1);
      note_on = 1'b0;
      step();
      chk("busy drop c4", 32'(drop), 0);
      repeat (2) step();
      chk("dual busy c6", 32'(busy), 0);
      chk("dual gate", 32'(voice_gate), 32'h1);
      chk("dual notes", 32'(voice_note), 32'd50);
      chk("dual trig", 32'(voice_trig), 32'h1);
      repeat (8) step();
      chk("dual late gate", 32'(voice_gate), 32'h1);
      chk("dual late notes", 32'(voice_note), 32'd50);
      chk("dual late busy", 32'(busy), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
